// File: rtl/cam_tag_data_if.sv
// cam_tag_data_if: bus bundle for the tag/data CAM.
//   master modport : requester side (drives i_* requests, reads status/results)
//   slave modport  : CAM side (reads requests, drives ow_* status and o_* results)
// Signals:
//   i_ins_valid/i_ins_tag/i_ins_data, ow_ins_ready : insert handshake
//   i_inv_valid/i_inv_tag, o_inv_miss               : invalidate by tag
//   i_lkp_valid/i_lkp_tag, o_lkp_*                  : lookup (1-cycle latency)
//   i_flush                                          : synchronous clear
//   ow_tags_empty/ow_tags_full/ow_count              : occupancy status
interface cam_tag_data_if #(
  parameter int N     = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 16
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic          i_ins_valid;
  logic [N-1:0]  i_ins_tag;
  logic [DW-1:0] i_ins_data;
  logic          ow_ins_ready;

  logic          i_inv_valid;
  logic [N-1:0]  i_inv_tag;
  logic          o_inv_miss;

  logic          i_lkp_valid;
  logic [N-1:0]  i_lkp_tag;
  logic          o_lkp_valid;
  logic          o_lkp_hit;
  logic [IW-1:0] o_lkp_index;
  logic [DW-1:0] o_lkp_data;

  logic          i_flush;
  logic          ow_tags_empty;
  logic          ow_tags_full;
  logic [CW-1:0] ow_count;

  modport master (
    output i_ins_valid, i_ins_tag, i_ins_data, i_inv_valid, i_inv_tag,
           i_lkp_valid, i_lkp_tag, i_flush,
    input  ow_ins_ready, o_inv_miss, o_lkp_valid, o_lkp_hit, o_lkp_index,
           o_lkp_data, ow_tags_empty, ow_tags_full, ow_count
  );

  modport slave (
    input  i_ins_valid, i_ins_tag, i_ins_data, i_inv_valid, i_inv_tag,
           i_lkp_valid, i_lkp_tag, i_flush,
    output ow_ins_ready, o_inv_miss, o_lkp_valid, o_lkp_hit, o_lkp_index,
           o_lkp_data, ow_tags_empty, ow_tags_full, ow_count
  );
endinterface

// File: rtl/cam_tag_data.sv
// cam_tag_data: fully associative tag/payload store with insert (update or
// allocate), invalidate-by-tag, registered lookup and synchronous flush.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : cam_tag_data_if slave modport (requests, results, status)
// All match/allocate decisions use pre-edge state; updates appear next cycle.
module cam_tag_data #(
  parameter int N     = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  cam_tag_data_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Lowest set bit position of a one-hot/multi-hot vector (0 when empty).
  function automatic logic [IW-1:0] low_index(input logic [DEPTH-1:0] vec);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = vec[i] ? IW'(i) : idx;
    end
    return idx;
  endfunction

  // Entry storage
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [N-1:0]     tag_q  [DEPTH];
  logic [N-1:0]     tag_d  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // Registered results
  logic             inv_miss_q, inv_miss_d;
  logic             lkp_valid_q, lkp_valid_d;
  logic             lkp_hit_q, lkp_hit_d;
  logic [IW-1:0]    lkp_index_q, lkp_index_d;
  logic [DW-1:0]    lkp_data_q, lkp_data_d;

  // Match / decision signals
  logic [DEPTH-1:0] ins_match_s, inv_match_s, lkp_match_s;
  logic             ins_hit_s, inv_hit_s, lkp_hit_s;
  logic [IW-1:0]    ins_idx_s, inv_idx_s, lkp_idx_s, free_idx_s;
  logic             full_s, ins_ready_s, ins_accept_s, alloc_s, inv_clr_s;

  // Per-entry tag comparators against the three request tags.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ins_match_s[i] = valid_q[i] && (tag_q[i] == bus.i_ins_tag);
      inv_match_s[i] = valid_q[i] && (tag_q[i] == bus.i_inv_tag);
      lkp_match_s[i] = valid_q[i] && (tag_q[i] == bus.i_lkp_tag);
    end
  end

  // Encode matches, pick the allocation slot and form the insert handshake.
  always_comb begin
    ins_hit_s  = |ins_match_s;
    inv_hit_s  = |inv_match_s;
    lkp_hit_s  = |lkp_match_s;
    ins_idx_s  = low_index(ins_match_s);
    inv_idx_s  = low_index(inv_match_s);
    lkp_idx_s  = low_index(lkp_match_s);
    // Free slot comes from pre-edge valid bits, so a slot being invalidated
    // this cycle is still seen as occupied and cannot be reused yet.
    free_idx_s = low_index(~valid_q);
    full_s     = (count_q == CW'(DEPTH));
    // An invalidate of the same tag always beats the insert.
    ins_ready_s  = (ins_hit_s || !full_s) &&
                   !(bus.i_inv_valid && (bus.i_inv_tag == bus.i_ins_tag));
    ins_accept_s = bus.i_ins_valid && ins_ready_s;
    alloc_s      = ins_accept_s && !ins_hit_s;
    inv_clr_s    = bus.i_inv_valid && inv_hit_s;
  end

  // Next state of the entry array, count and invalidate-miss pulse.
  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    count_d    = count_q;
    inv_miss_d = 1'b0;
    if (bus.i_flush) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      if (inv_clr_s) begin
        valid_d[inv_idx_s] = 1'b0;
      end else begin
        valid_d = valid_d;
      end
      if (ins_accept_s && ins_hit_s) begin
        data_d[ins_idx_s] = bus.i_ins_data;
      end else if (alloc_s) begin
        valid_d[free_idx_s] = 1'b1;
        tag_d[free_idx_s]   = bus.i_ins_tag;
        data_d[free_idx_s]  = bus.i_ins_data;
      end else begin
        data_d = data_d;
      end
      // Allocation and invalidate may coincide: net change is zero.
      count_d    = count_q + CW'(alloc_s) - CW'(inv_clr_s);
      inv_miss_d = bus.i_inv_valid && !inv_hit_s;
    end
  end

  // Lookup result: sampled on a request, held otherwise (valid drops).
  always_comb begin
    lkp_valid_d = bus.i_lkp_valid;
    if (bus.i_lkp_valid) begin
      lkp_hit_d   = lkp_hit_s;
      lkp_index_d = lkp_hit_s ? lkp_idx_s : '0;
      lkp_data_d  = lkp_hit_s ? data_q[lkp_idx_s] : '0;
    end else begin
      lkp_hit_d   = lkp_hit_q;
      lkp_index_d = lkp_index_q;
      lkp_data_d  = lkp_data_q;
    end
  end

  // State and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q     <= '0;
      count_q     <= '0;
      inv_miss_q  <= 1'b0;
      lkp_valid_q <= 1'b0;
      lkp_hit_q   <= 1'b0;
      lkp_index_q <= '0;
      lkp_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      inv_miss_q  <= inv_miss_d;
      lkp_valid_q <= lkp_valid_d;
      lkp_hit_q   <= lkp_hit_d;
      lkp_index_q <= lkp_index_d;
      lkp_data_q  <= lkp_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Output drive.
  always_comb begin
    bus.ow_ins_ready  = ins_ready_s;
    bus.o_inv_miss    = inv_miss_q;
    bus.o_lkp_valid   = lkp_valid_q;
    bus.o_lkp_hit     = lkp_hit_q;
    bus.o_lkp_index   = lkp_index_q;
    bus.o_lkp_data    = lkp_data_q;
    bus.ow_count      = count_q;
    bus.ow_tags_empty = (count_q == '0);
    bus.ow_tags_full  = full_s;
  end

endmodule

// File: tb/tb_cam_tag_data.sv
// Directed table-driven bench for cam_tag_data (DEPTH=4, N=8, DW=16).
module tb_cam_tag_data;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cam_tag_data_if #(.N(8), .DW(16), .DEPTH(4)) bus ();

  cam_tag_data #(.N(8), .DW(16), .DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ins_v;
    logic [7:0]  ins_tag;
    logic [15:0] ins_data;
    logic        inv_v;
    logic [7:0]  inv_tag;
    logic        lkp_v;
    logic [7:0]  lkp_tag;
    logic        flush;
    logic        e_ready;
    logic [2:0]  e_count;
    logic        e_lv;
    logic        e_hit;
    logic [1:0]  e_idx;
    logic [15:0] e_data;
    logic        e_miss;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic iv, input logic [7:0] it, input logic [15:0] id,
    input logic vv, input logic [7:0] vt,
    input logic lv, input logic [7:0] lt, input logic fl,
    input logic er, input logic [2:0] ec,
    input logic elv, input logic eh, input logic [1:0] ei,
    input logic [15:0] ed, input logic em);
    vec_t v;
    v.ins_v = iv; v.ins_tag = it; v.ins_data = id;
    v.inv_v = vv; v.inv_tag = vt;
    v.lkp_v = lv; v.lkp_tag = lt; v.flush = fl;
    v.e_ready = er; v.e_count = ec;
    v.e_lv = elv; v.e_hit = eh; v.e_idx = ei; v.e_data = ed; v.e_miss = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_ins_valid = 1'b0; bus.i_ins_tag = 8'h00; bus.i_ins_data = 16'h0000;
    bus.i_inv_valid = 1'b0; bus.i_inv_tag = 8'h00;
    bus.i_lkp_valid = 1'b0; bus.i_lkp_tag = 8'h00;
    bus.i_flush     = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [2:0] cnt);
    chk({tag, "_count"}, 32'(bus.ow_count), 32'(cnt));
    chk({tag, "_empty"}, 32'(bus.ow_tags_empty), 32'(cnt == 3'd0));
    chk({tag, "_full"},  32'(bus.ow_tags_full),  32'(cnt == 3'd4));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive_idle();

    //              ins  tag    data      inv tag    lkp tag    fl rdy cnt lv hit idx data     miss
    vecs[0]  = mk(1'b1,8'h11,16'h1111, 1'b0,8'h00, 1'b0,8'h00, 1'b0, 1'b1,3'd1, 1'b0,1'b0,2'd0,16'h0000,1'b0);
    vecs[1]  = mk(1'b1,8'h22,16'h2222, 1'b0,8'h00, 1'b0,8'h00, 1'b0, 1'b1,3'd2, 1'b0,1'b0,2'd0,16'h0000,1'b0);
    vecs[2]  = mk(1'b1,8'h33,16'h3333, 1'b0,8'h00, 1'b0,8'h00, 1'b0, 1'b1,3'd3, 1'b0,1'b0,2'd0,16'h0000,1'b0);
    vecs[3]  = mk(1'b1,8'h44,16'h4444, 1'b0,8'h00, 1'b0,8'h00, 1'b0, 1'b1,3'd4, 1'b0,1'b0,2'd0,16'h0000,1'b0);
    vecs[4]  = mk(1'b1,8'h55,16'h5555, 1'b0,8'h00, 1'b0,8'h00, 1'b0, 1'b0,3'd4, 1'b0,1'b0,2'd0,16'h0000,1'b0);
    vecs[5]  = mk(1'b0,8'h00,16'h0000, 1'b0,8'h00, 1'b1,8'h55, 1'b0, 1'b0,3'd4, 1'b1,1'b0,2'd0,16'h0000,1'b0);
    vecs[6]  = mk(1'b0,8'h00,16'h0000, 1'b0,8'h00, 1'b1,8'h44, 1'b0, 1'b0,3'd4, 1'b1,1'b1,2'd3,16'h4444,1'b0);
    vecs[7]  = mk(1'b1,8'h22,16'hBEEF, 1'b0,8'h00, 1'b0,8'h00, 1'b0, 1'b1,3'd4, 1'b0,1'b1,2'd3,16'h4444,1'b0);
    vecs[8]  = mk(1'b0,8'h00,16'h0000, 1'b0,8'h00, 1'b1,8'h22, 1'b0, 1'b0,3'd4, 1'b1,1'b1,2'd1,16'hBEEF,1'b0);
    vecs[9]  = mk(1'b1,8'h55,16'h5555, 1'b1,8'h11, 1'b0,8'h00, 1'b0, 1'b0,3'd3, 1'b0,1'b1,2'd1,16'hBEEF,1'b0);
    vecs[10] = mk(1'b1,8'h55,16'h5555, 1'b0,8'h00, 1'b0,8'h00, 1'b0, 1'b1,3'd4, 1'b0,1'b1,2'd1,16'hBEEF,1'b0);
    vecs[11] = mk(1'b0,8'h00,16'h0000, 1'b0,8'h00, 1'b1,8'h55, 1'b0, 1'b0,3'd4, 1'b1,1'b1,2'd0,16'h5555,1'b0);
    vecs[12] = mk(1'b0,8'h00,16'h0000, 1'b1,8'h99, 1'b0,8'h00, 1'b0, 1'b0,3'd4, 1'b0,1'b1,2'd0,16'h5555,1'b1);
    vecs[13] = mk(1'b0,8'h00,16'h0000, 1'b0,8'h00, 1'b0,8'h00, 1'b0, 1'b0,3'd4, 1'b0,1'b1,2'd0,16'h5555,1'b0);
    vecs[14] = mk(1'b0,8'h00,16'h0000, 1'b1,8'h44, 1'b0,8'h00, 1'b0, 1'b0,3'd3, 1'b0,1'b1,2'd0,16'h5555,1'b0);
    vecs[15] = mk(1'b1,8'h66,16'h6666, 1'b1,8'h66, 1'b0,8'h00, 1'b0, 1'b0,3'd3, 1'b0,1'b1,2'd0,16'h5555,1'b1);
    vecs[16] = mk(1'b0,8'h00,16'h0000, 1'b1,8'h33, 1'b1,8'h33, 1'b0, 1'b1,3'd2, 1'b1,1'b1,2'd2,16'h3333,1'b0);
    vecs[17] = mk(1'b0,8'h00,16'h0000, 1'b0,8'h00, 1'b1,8'h33, 1'b0, 1'b1,3'd2, 1'b1,1'b0,2'd0,16'h0000,1'b0);
    vecs[18] = mk(1'b1,8'h77,16'h7777, 1'b0,8'h00, 1'b0,8'h00, 1'b1, 1'b1,3'd0, 1'b0,1'b0,2'd0,16'h0000,1'b0);
    vecs[19] = mk(1'b0,8'h00,16'h0000, 1'b0,8'h00, 1'b1,8'h77, 1'b0, 1'b1,3'd0, 1'b1,1'b0,2'd0,16'h0000,1'b0);
    vecs[20] = mk(1'b1,8'h11,16'hAAAA, 1'b0,8'h00, 1'b0,8'h00, 1'b0, 1'b1,3'd1, 1'b0,1'b0,2'd0,16'h0000,1'b0);
    vecs[21] = mk(1'b1,8'h22,16'hBBBB, 1'b1,8'h11, 1'b0,8'h00, 1'b0, 1'b1,3'd1, 1'b0,1'b0,2'd0,16'h0000,1'b0);
    vecs[22] = mk(1'b0,8'h00,16'h0000, 1'b0,8'h00, 1'b1,8'h22, 1'b0, 1'b1,3'd1, 1'b1,1'b1,2'd1,16'hBBBB,1'b0);
    vecs[23] = mk(1'b0,8'h00,16'h0000, 1'b1,8'h99, 1'b0,8'h00, 1'b1, 1'b1,3'd0, 1'b0,1'b1,2'd1,16'hBBBB,1'b0);

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_status("rst", 3'd0);
    chk("rst_lkp_valid", 32'(bus.o_lkp_valid), 32'd0);
    chk("rst_lkp_hit",   32'(bus.o_lkp_hit),   32'd0);
    chk("rst_lkp_index", 32'(bus.o_lkp_index), 32'd0);
    chk("rst_lkp_data",  32'(bus.o_lkp_data),  32'd0);
    chk("rst_inv_miss",  32'(bus.o_inv_miss),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drive on negedge, check ready before the edge, results after.
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      bus.i_ins_valid = vecs[k].ins_v;
      bus.i_ins_tag   = vecs[k].ins_tag;
      bus.i_ins_data  = vecs[k].ins_data;
      bus.i_inv_valid = vecs[k].inv_v;
      bus.i_inv_tag   = vecs[k].inv_tag;
      bus.i_lkp_valid = vecs[k].lkp_v;
      bus.i_lkp_tag   = vecs[k].lkp_tag;
      bus.i_flush     = vecs[k].flush;
      #1;
      chk($sformatf("v%0d_ready", k), 32'(bus.ow_ins_ready), 32'(vecs[k].e_ready));
      @(posedge clk);
      #1;
      check_status($sformatf("v%0d", k), vecs[k].e_count);
      chk($sformatf("v%0d_lkp_valid", k), 32'(bus.o_lkp_valid), 32'(vecs[k].e_lv));
      chk($sformatf("v%0d_lkp_hit", k),   32'(bus.o_lkp_hit),   32'(vecs[k].e_hit));
      chk($sformatf("v%0d_lkp_index", k), 32'(bus.o_lkp_index), 32'(vecs[k].e_idx));
      chk($sformatf("v%0d_lkp_data", k),  32'(bus.o_lkp_data),  32'(vecs[k].e_data));
      chk($sformatf("v%0d_inv_miss", k),  32'(bus.o_inv_miss),  32'(vecs[k].e_miss));
    end

    // Async reset in the middle of a lookup.
    @(negedge clk);
    drive_idle();
    bus.i_ins_valid = 1'b1; bus.i_ins_tag = 8'h5A; bus.i_ins_data = 16'h1234;
    @(posedge clk);
    #1;
    check_status("seed", 3'd1);
    @(negedge clk);
    drive_idle();
    bus.i_lkp_valid = 1'b1; bus.i_lkp_tag = 8'h5A;
    #2;
    rst_n = 1'b0;
    #1;
    check_status("arst", 3'd0);
    chk("arst_lkp_valid", 32'(bus.o_lkp_valid), 32'd0);
    chk("arst_lkp_data",  32'(bus.o_lkp_data),  32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_lkp_valid", 32'(bus.o_lkp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_lkp_valid", 32'(bus.o_lkp_valid), 32'd0);
    @(posedge clk);
    #1;
    // Lookup still asserted: entry 0x5A was wiped by reset.
    chk("rel2_lkp_valid", 32'(bus.o_lkp_valid), 32'd1);
    chk("rel2_lkp_hit",   32'(bus.o_lkp_hit),   32'd0);
    chk("rel2_lkp_data",  32'(bus.o_lkp_data),  32'd0);
    check_status("rel2", 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
